// File: rtl/bounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_pkg
//  Description : Sound codes and screen-limit helpers shared by the bounce
//                engine and its per-axis datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package bounce_pkg;

    typedef enum logic [1:0] {
        STOP = 2'b00,
        PONG = 2'b01,
        PING = 2'b10,
        GO   = 2'b11
    } sound_t;

    function automatic int lim_min(input int border);
        return border;
    endfunction

    function automatic int lim_max(input int res, input int logo, input int border);
        return res - logo - border;
    endfunction

    function automatic int centre(input int res, input int logo);
        return (res - logo) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_axis
//  Description : One axis of logo motion: position/velocity registers with
//                wall reflection inside [MIN, MAX] and a bounce flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_axis #(
    parameter int MIN    = 0,
    parameter int MAX    = 560,
    parameter int CW     = 10,
    parameter int VW     = 4,
    parameter int V_INIT = 1,
    parameter int P_INIT = 280
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_tick,
    output logic [CW-1:0] o_pos,
    output logic          o_hit
);

    localparam logic signed [CW+1:0] c_min = (CW+2)'(MIN);
    localparam logic signed [CW+1:0] c_max = (CW+2)'(MAX);

    logic        [CW-1:0]   r_pos;
    logic signed [VW-1:0]   r_vel;
    logic signed [CW+1:0]   w_sum;
    logic signed [CW+1:0]   w_pos_next;
    logic signed [VW-1:0]   w_vel_next;
    logic                   w_wall;

    // Two guard bits keep the unreflected sum signed and unclipped.
    always_comb begin
        w_sum      = $signed({2'b00, r_pos}) + $signed({{(CW+2-VW){r_vel[VW-1]}}, r_vel});
        w_pos_next = w_sum;
        w_vel_next = r_vel;
        w_wall     = 1'b0;
        if (w_sum >= c_max) begin
            w_pos_next = (c_max <<< 1) - w_sum;
            w_vel_next = -r_vel;
            w_wall     = 1'b1;
        end else if (w_sum <= c_min) begin
            w_pos_next = (c_min <<< 1) - w_sum;
            w_vel_next = -r_vel;
            w_wall     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_pos <= CW'(P_INIT);
            r_vel <= VW'(V_INIT);
        end else if (i_tick) begin
            r_pos <= w_pos_next[CW-1:0];
            r_vel <= w_vel_next;
        end
    end

    assign o_pos = r_pos;
    assign o_hit = i_tick & w_wall;

endmodule
`default_nettype wire

// File: rtl/bounce_engine.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_engine
//  Description : Screen-saver logo motion engine: prescaled motion tick,
//                edge-detected saturating speed control, bounce hit pulse
//                and timed sound envelope.
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_engine
    import bounce_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int WIDTH_LOGO  = 80,
    parameter int HEIGHT_LOGO = 96,
    parameter int BORDER      = 0,
    parameter int CW          = 10,
    parameter int VW          = 4,
    parameter int VX_INIT     = 1,
    parameter int VY_INIT     = 2,
    parameter int LVL_MIN     = 0,
    parameter int LVL_MAX     = 23,
    parameter int LVL_INIT    = 16,
    parameter int DIV_W       = 24,
    parameter int SOUND_TICKS = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          pause,
    input  logic          inc_vel,
    input  logic          dec_vel,
    output logic [CW-1:0] x_logo,
    output logic [CW-1:0] y_logo,
    output logic          hit,
    output logic [1:0]    code_sound,
    output logic          mute
);

    localparam int c_lw = $clog2(LVL_MAX + 1);
    localparam int c_tw = $clog2(SOUND_TICKS + 2);

    localparam logic [c_lw-1:0] c_lvl_min  = c_lw'(LVL_MIN);
    localparam logic [c_lw-1:0] c_lvl_max  = c_lw'(LVL_MAX);
    localparam logic [c_lw-1:0] c_lvl_init = c_lw'(LVL_INIT);
    localparam logic [c_tw-1:0] c_tmr_init = c_tw'(SOUND_TICKS);

    localparam int c_x_min = lim_min(BORDER);
    localparam int c_x_max = lim_max(H_RES, WIDTH_LOGO, BORDER);
    localparam int c_y_min = lim_min(BORDER);
    localparam int c_y_max = lim_max(V_RES, HEIGHT_LOGO, BORDER);

    logic [DIV_W-1:0] r_div;
    logic [c_lw-1:0]  r_lvl;
    logic [c_lw-1:0]  w_lvl_next;
    logic [c_lw:0]    w_shamt;
    logic [DIV_W-1:0] w_mask;
    logic             r_inc_d;
    logic             r_dec_d;
    logic             w_inc_edge;
    logic             w_dec_edge;
    logic             w_tick;
    logic             w_hx;
    logic             w_hy;
    logic             r_hit;
    logic             r_mute;
    sound_t           r_code;
    logic [c_tw-1:0]  r_timer;

    assign w_inc_edge = inc_vel & ~r_inc_d;
    assign w_dec_edge = dec_vel & ~r_dec_d;

    // Tick when the low lvl+1 prescaler bits are all ones.
    assign w_shamt = {1'b0, r_lvl} + 1'b1;
    assign w_mask  = ~({DIV_W{1'b1}} << w_shamt);
    assign w_tick  = ~pause & ((r_div & w_mask) == w_mask);

    always_comb begin
        w_lvl_next = r_lvl;
        if (w_inc_edge && !w_dec_edge && (r_lvl > c_lvl_min))
            w_lvl_next = r_lvl - 1'b1;
        else if (w_dec_edge && !w_inc_edge && (r_lvl < c_lvl_max))
            w_lvl_next = r_lvl + 1'b1;
    end

    bounce_axis #(
        .MIN    (c_x_min),
        .MAX    (c_x_max),
        .CW     (CW),
        .VW     (VW),
        .V_INIT (VX_INIT),
        .P_INIT (centre(H_RES, WIDTH_LOGO))
    ) u_axis_x (
        .clk    (clk),
        .clr    (clr),
        .i_tick (w_tick),
        .o_pos  (x_logo),
        .o_hit  (w_hx)
    );

    bounce_axis #(
        .MIN    (c_y_min),
        .MAX    (c_y_max),
        .CW     (CW),
        .VW     (VW),
        .V_INIT (VY_INIT),
        .P_INIT (centre(V_RES, HEIGHT_LOGO))
    ) u_axis_y (
        .clk    (clk),
        .clr    (clr),
        .i_tick (w_tick),
        .o_pos  (y_logo),
        .o_hit  (w_hy)
    );

    always_ff @(posedge clk) begin
        // Edge detectors track the inputs even through reset.
        r_inc_d <= inc_vel;
        r_dec_d <= dec_vel;
        if (!clr) begin
            r_div   <= '0;
            r_lvl   <= c_lvl_init;
            r_hit   <= 1'b0;
            r_mute  <= 1'b0;
            r_code  <= GO;
            r_timer <= c_tmr_init;
        end else begin
            r_lvl <= w_lvl_next;
            if (w_lvl_next != r_lvl)
                r_div <= '0;
            else if (!pause)
                r_div <= r_div + 1'b1;

            if (w_tick) begin
                r_hit <= w_hx | w_hy;
                if (w_hx | w_hy) begin
                    r_mute  <= 1'b0;
                    r_timer <= c_tmr_init;
                    r_code  <= (w_hx && w_hy) ? GO : (w_hx ? PONG : PING);
                end else if (r_timer != '0) begin
                    r_timer <= r_timer - 1'b1;
                    if (r_timer == c_tw'(1)) begin
                        r_mute <= 1'b1;
                        r_code <= STOP;
                    end
                end
            end else begin
                r_hit <= 1'b0;
            end
        end
    end

    assign hit        = r_hit;
    assign mute       = r_mute;
    assign code_sound = r_code;

endmodule
`default_nettype wire

// File: tb/tb_bounce_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_engine
//  Description : Scoreboard bench for bounce_engine: a cycle model predicts
//                each post-edge output set, queued and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_engine;

    logic       clk = 1'b0;
    logic       clr, pause, inc_vel, dec_vel;
    logic [9:0] x_logo, y_logo;
    logic       hit, mute;
    logic [1:0] code_sound;

    logic       clr_c, zero_c;
    logic [9:0] x_c, y_c;
    logic       hit_c, mute_c;
    logic [1:0] code_c;

    always #5 clk = ~clk;

    bounce_engine #(.LVL_INIT(0)) dut (
        .clk(clk), .clr(clr), .pause(pause), .inc_vel(inc_vel), .dec_vel(dec_vel),
        .x_logo(x_logo), .y_logo(y_logo), .hit(hit), .code_sound(code_sound), .mute(mute)
    );

    bounce_engine #(
        .H_RES(200), .V_RES(200), .WIDTH_LOGO(100), .HEIGHT_LOGO(100),
        .VX_INIT(2), .VY_INIT(2), .LVL_INIT(0)
    ) dut_c (
        .clk(clk), .clr(clr_c), .pause(zero_c), .inc_vel(zero_c), .dec_vel(zero_c),
        .x_logo(x_c), .y_logo(y_c), .hit(hit_c), .code_sound(code_c), .mute(mute_c)
    );

    typedef struct {
        int x; int y; int h; int code; int mute;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_bad = 0;

    int mx, my, mvx, mvy, mlvl, mdiv, mtimer, mcode, mmute, mhit;
    bit pinc, pdec;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic refl(inout int p, inout int v, input int lo, input int hi, output bit h);
        int n;
        n = p + v;
        h = 1'b0;
        if (n >= hi) begin
            p = 2 * hi - n; v = -v; h = 1'b1;
        end else if (n <= lo) begin
            p = 2 * lo - n; v = -v; h = 1'b1;
        end else begin
            p = n;
        end
    endtask

    task automatic model(input bit c, input bit i, input bit d, input bit p);
        int per, nl;
        bit tk, ie, de, hx, hy;
        if (!c) begin
            mx = 280; my = 192; mvx = 1; mvy = 2; mlvl = 0; mdiv = 0;
            mhit = 0; mcode = 3; mmute = 0; mtimer = 4;
        end else begin
            per = 1 << (mlvl + 1);
            tk  = !p && ((mdiv % per) == per - 1);
            ie  = i && !pinc;
            de  = d && !pdec;
            nl  = mlvl;
            if (ie && !de && mlvl > 0)  nl = mlvl - 1;
            if (de && !ie && mlvl < 23) nl = mlvl + 1;
            if (nl != mlvl) mdiv = 0;
            else if (!p)    mdiv = (mdiv + 1) % (1 << 24);
            mlvl = nl;
            mhit = 0;
            if (tk) begin
                refl(mx, mvx, 0, 560, hx);
                refl(my, mvy, 0, 384, hy);
                if (hx || hy) begin
                    mhit = 1; mmute = 0; mtimer = 4;
                    mcode = (hx && hy) ? 3 : (hx ? 1 : 2);
                end else if (mtimer > 0) begin
                    mtimer--;
                    if (mtimer == 0) begin mmute = 1; mcode = 0; end
                end
            end
        end
        pinc = i;
        pdec = d;
    endtask

    task automatic step(input bit c, input bit i, input bit d, input bit p);
        exp_t e;
        clr = c; inc_vel = i; dec_vel = d; pause = p;
        model(c, i, d, p);
        q.push_back('{mx, my, mhit, mcode, mmute});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("x", int'(x_logo), e.x);
        chk("y", int'(y_logo), e.y);
        chk("hit", int'(hit), e.h);
        chk("code", int'(code_sound), e.code);
        chk("mute", int'(mute), e.mute);
    endtask

    initial begin
        int n, px, py, pm, xs;
        clr = 1'b0; pause = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
        clr_c = 1'b0; zero_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Corner geometry: both walls reached on tick 25 (edge 50).
        clr_c = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            if (hit_c) break;
        end
        chk("corner_edge", n, 50);
        chk("corner_x", int'(x_c), 100);
        chk("corner_y", int'(y_c), 100);
        chk("corner_code", int'(code_c), 3);
        @(posedge clk); #1;
        chk("corner_hit_width", int'(hit_c), 0);
        @(posedge clk); #1;
        chk("corner_x_back", int'(x_c), 98);
        chk("corner_y_back", int'(y_c), 98);
        clr_c = 1'b0;

        // Reset state and sound timeout.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_x", int'(x_logo), 280);
        chk("rst_y", int'(y_logo), 192);
        chk("rst_code", int'(code_sound), 3);
        chk("rst_mute", int'(mute), 0);
        chk("rst_hit", int'(hit), 0);
        repeat (8) step(1, 0, 0, 0);
        chk("timeout_mute", int'(mute), 1);
        chk("timeout_code", int'(code_sound), 0);

        // Floor at tick 96, right wall at tick 280.
        repeat (184) step(1, 0, 0, 0);
        chk("floor_y", int'(y_logo), 384);
        chk("floor_x", int'(x_logo), 376);
        chk("floor_code", int'(code_sound), 2);
        chk("floor_hit", int'(hit), 1);
        repeat (368) step(1, 0, 0, 0);
        chk("wall_x", int'(x_logo), 560);
        chk("wall_code", int'(code_sound), 1);
        chk("wall_hit", int'(hit), 1);
        step(1, 0, 0, 0);
        chk("wall_hit_width", int'(hit), 0);
        step(1, 0, 0, 0);
        chk("wall_x_back", int'(x_logo), 559);
        repeat (40) step(1, 0, 0, 0);

        // Pause freezes motion and sound.
        px = mx; py = my; pm = mmute;
        repeat (1000) step(1, 0, 0, 1);
        chk("pause_x", int'(x_logo), px);
        chk("pause_y", int'(y_logo), py);
        chk("pause_mute", int'(mute), pm);
        repeat (6) step(1, 0, 0, 0);

        // Reset on what would be the tick-96 floor hit.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (191) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_hit_tick_hit", int'(hit), 0);
        chk("rst_hit_tick_x", int'(x_logo), 280);
        chk("rst_hit_tick_y", int'(y_logo), 192);
        repeat (3) step(1, 0, 0, 0);

        // Simultaneous edges, saturation, then return to lvl 0.
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0);
        repeat (30) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
        repeat (23) begin step(1, 1, 0, 0); step(1, 0, 0, 0); end
        repeat (12) step(1, 0, 0, 0);

        // lvl 16 -> held inc -> lvl 15, next tick 65536 cycles on.
        repeat (16) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
        step(1, 1, 0, 0);
        xs = mx;
        n = 0;
        while (n < 70000) begin
            step(1, n < 9, 0, 0);
            n++;
            if (int'(x_logo) != xs) break;
        end
        chk("lvl15_period", n, 65536);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
